// File: rtl/fp_to_gp_share_arbiter_pkg.sv
// Types shared by the FP-to-GP share arbiter, its ownership FIFO and the requesters:
// operation/id types, the per-requester request bundle and the requester count.
package fp_to_gp_share_arbiter_pkg;

    localparam int ID_W                    = 3;
    localparam int FLOPOCO_W               = 34;
    localparam int FP_TO_GP_ARB_REQUESTERS = 2;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [2:0] {
        FPCVT_W_OP,
        FPCVT_WU_OP,
        FPMV_X_W_OP,
        FPEQ_OP,
        FPLT_OP,
        FPLE_OP,
        FPCLASS_OP
    } fp_to_gp_op_t;

    typedef struct packed {
        fp_to_gp_op_t         op;
        logic [FLOPOCO_W-1:0] rs1;
        logic [FLOPOCO_W-1:0] rs2;
        id_t                  id;
    } fp_to_gp_arb_req_t;

endpackage

// File: rtl/fp_to_gp_share_arbiter_own_fifo.sv
// Ownership FIFO: one bit per in-flight operation naming the requester that issued it.
// Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices.
module fp_to_gp_arb_own_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic owner_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] owner_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = owner_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot at the same edge, so a push into a full FIFO is safe then.
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage has no reset; its contents are never read while the
    // pointers say empty, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            owner_q[wr_ptr_q[AW-1:0]] <= owner_i;
        end
    end

endmodule

// File: rtl/fp_to_gp_share_arbiter.sv
// Round-robin share of one FP-to-GP unit between two issue sources, with in-order writeback
// routing. Define FP_TO_GP_ARB_STATS_EN to add saturating grant/conflict counters.
module fp_to_gp_share_arbiter
    import fp_to_gp_share_arbiter_pkg::*;
#(
    parameter int OWN_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  fp_to_gp_op_t         req_op  [FP_TO_GP_ARB_REQUESTERS],
    input  logic [FLOPOCO_W-1:0] req_rs1 [FP_TO_GP_ARB_REQUESTERS],
    input  logic [FLOPOCO_W-1:0] req_rs2 [FP_TO_GP_ARB_REQUESTERS],
    input  id_t                  req_id  [FP_TO_GP_ARB_REQUESTERS],
    output logic                 unit_new_request,
    input  logic                 unit_ready,
    output fp_to_gp_op_t         unit_op,
    output logic [FLOPOCO_W-1:0] unit_rs1,
    output logic [FLOPOCO_W-1:0] unit_rs2,
    output id_t                  unit_id,
    input  logic                 unit_done,
    input  id_t                  unit_wb_id,
    input  logic [31:0]          unit_rd,
    output logic                 unit_ack,
    output logic [1:0]           rsp_done,
    output id_t                  rsp_id,
    output logic [31:0]          rsp_rd,
    input  logic [1:0]           rsp_ack
`ifdef FP_TO_GP_ARB_STATS_EN
    ,
    output logic [31:0]          stat_grants0,
    output logic [31:0]          stat_grants1,
    output logic [31:0]          stat_conflicts
`endif
);
    fp_to_gp_arb_req_t req [FP_TO_GP_ARB_REQUESTERS];
    fp_to_gp_arb_req_t sel_req;
    logic [1:0]        grant;
    logic              prio_q, prio_d;
    logic              can_issue;
    logic              fifo_full, fifo_empty, fifo_head;
    logic              rsp_active;
    logic              wb_pop;

    always_comb begin
        for (int i = 0; i < FP_TO_GP_ARB_REQUESTERS; i++) begin
            req[i] = '{op: req_op[i], rs1: req_rs1[i], rs2: req_rs2[i], id: req_id[i]};
        end
    end

    assign can_issue = !rst && unit_ready && !fifo_full;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        if (can_issue) begin
            if (&req_valid) begin
                grant[prio_q] = 1'b1;
            end else begin
                grant = req_valid;
            end
        end
    end

    // Priority passes to whichever requester did not just win.
    always_comb begin
        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign sel_req          = req[grant[1]];
    assign req_ready        = grant;
    assign unit_new_request = |grant;
    assign unit_op          = sel_req.op;
    assign unit_rs1         = sel_req.rs1;
    assign unit_rs2         = sel_req.rs2;
    assign unit_id          = sel_req.id;

    fp_to_gp_arb_own_fifo #(
        .DEPTH (OWN_DEPTH)
    ) u_own_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (|grant),
        .owner_i (grant[1]),
        .pop_i   (wb_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Results return in issue order, so the FIFO head names the owner of the current writeback.
    assign rsp_active = !rst && !fifo_empty;
    assign rsp_done   = (unit_done && rsp_active) ? (2'b01 << fifo_head) : 2'b00;
    assign rsp_id     = unit_wb_id;
    assign rsp_rd     = unit_rd;
    assign unit_ack   = rsp_active && rsp_ack[fifo_head];
    assign wb_pop     = unit_done && unit_ack;

    wb_has_owner: assert property (@(posedge clk) disable iff (rst) unit_done |-> !fifo_empty);

`ifdef FP_TO_GP_ARB_STATS_EN
    logic [31:0] stat_grants0_q, stat_grants1_q, stat_conflicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants0_q   <= '0;
            stat_grants1_q   <= '0;
            stat_conflicts_q <= '0;
        end else begin
            if (grant[0] && (stat_grants0_q != '1)) begin
                stat_grants0_q <= stat_grants0_q + 32'd1;
            end
            if (grant[1] && (stat_grants1_q != '1)) begin
                stat_grants1_q <= stat_grants1_q + 32'd1;
            end
            if ((&req_valid) && (stat_conflicts_q != '1)) begin
                stat_conflicts_q <= stat_conflicts_q + 32'd1;
            end
        end
    end

    assign stat_grants0   = stat_grants0_q;
    assign stat_grants1   = stat_grants1_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_fp_to_gp_share_arbiter.sv
// Bench for fp_to_gp_share_arbiter: a stand-in in-order unit with a configurable queue,
// directed scenarios and a randomized run checked against a queue-based reference model.
module tb_fp_to_gp_share_arbiter;
    import fp_to_gp_share_arbiter_pkg::*;

    localparam int OWN_DEPTH = 2;
    localparam int UQ        = 8;

    typedef struct {
        int          owner;
        id_t         id;
        logic [31:0] rd;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    fp_to_gp_op_t         req_op  [2];
    logic [FLOPOCO_W-1:0] req_rs1 [2];
    logic [FLOPOCO_W-1:0] req_rs2 [2];
    id_t                  req_id  [2];
    logic                 unit_new_request;
    logic                 unit_ready;
    fp_to_gp_op_t         unit_op;
    logic [FLOPOCO_W-1:0] unit_rs1, unit_rs2;
    id_t                  unit_id;
    logic                 unit_done;
    id_t                  unit_wb_id;
    logic [31:0]          unit_rd;
    logic                 unit_ack;
    logic [1:0]           rsp_done;
    id_t                  rsp_id;
    logic [31:0]          rsp_rd;
    logic [1:0]           rsp_ack;
`ifdef FP_TO_GP_ARB_STATS_EN
    logic [31:0]          stat_grants0, stat_grants1, stat_conflicts;
`endif

    int checks   = 0;
    int failures = 0;

    // Stand-in unit: in-order result queue, results visible one cycle after issue.
    logic [31:0] u_rd [UQ];
    id_t         u_id [UQ];
    int          u_head;
    int          u_cnt;
    int          unit_cap;
    logic        unit_stall;

    // Reference model: expected writebacks in issue order plus the last winner.
    exp_t        exp_q[$];
    int          last_winner;
    logic [1:0]  last_grant;

    always #5 clk = ~clk;

    fp_to_gp_share_arbiter #(
        .OWN_DEPTH (OWN_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_rs1          (req_rs1),
        .req_rs2          (req_rs2),
        .req_id           (req_id),
        .unit_new_request (unit_new_request),
        .unit_ready       (unit_ready),
        .unit_op          (unit_op),
        .unit_rs1         (unit_rs1),
        .unit_rs2         (unit_rs2),
        .unit_id          (unit_id),
        .unit_done        (unit_done),
        .unit_wb_id       (unit_wb_id),
        .unit_rd          (unit_rd),
        .unit_ack         (unit_ack),
        .rsp_done         (rsp_done),
        .rsp_id           (rsp_id),
        .rsp_rd           (rsp_rd),
        .rsp_ack          (rsp_ack)
`ifdef FP_TO_GP_ARB_STATS_EN
        ,
        .stat_grants0     (stat_grants0),
        .stat_grants1     (stat_grants1),
        .stat_conflicts   (stat_conflicts)
`endif
    );

    function automatic logic [31:0] unit_fn(fp_to_gp_op_t op, logic [33:0] a, logic [33:0] b);
        if (op == FPEQ_OP) return {31'd0, a == b};
        return a[31:0] + b[31:0] + 32'(op);
    endfunction

    assign unit_ready = (u_cnt < unit_cap) && !unit_stall;
    assign unit_done  = (u_cnt > 0);
    assign unit_wb_id = u_id[u_head];
    assign unit_rd    = u_rd[u_head];

    always @(posedge clk) begin
        if (rst) begin
            u_head <= 0;
            u_cnt  <= 0;
        end else begin
            if (unit_new_request) begin
                u_id[(u_head + u_cnt) % UQ] <= unit_id;
                u_rd[(u_head + u_cnt) % UQ] <= unit_fn(unit_op, unit_rs1, unit_rs2);
            end
            if (unit_done && unit_ack) u_head <= (u_head + 1) % UQ;
            u_cnt <= u_cnt + (unit_new_request ? 1 : 0) - ((unit_done && unit_ack) ? 1 : 0);
        end
    end

    function automatic int exp_winner();
        if (rst || !unit_ready || exp_q.size() >= OWN_DEPTH) return -1;
        if (req_valid == 2'b11) return (last_winner == 0) ? 1 : 0;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] exp_done();
        if (rst || !unit_done || exp_q.size() == 0) return 2'b00;
        return (exp_q[0].owner == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic exp_ack();
        if (rst || exp_q.size() == 0) return 1'b0;
        return rsp_ack[exp_q[0].owner];
    endfunction

    // Apply this cycle's expected handshakes to the model, then move to the next drive point.
    task automatic next_cycle();
        int   w;
        logic pop;
        w   = exp_winner();
        pop = unit_done && exp_ack();
        if (rst) begin
            exp_q.delete();
            last_winner = -1;
            last_grant  = 2'b00;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (w >= 0) begin
                exp_q.push_back('{w, req_id[w], unit_fn(req_op[w], req_rs1[w], req_rs2[w])});
                last_winner = w;
            end
            last_grant = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, fp_to_gp_op_t op, logic [33:0] a, logic [33:0] b, id_t id);
        req_op[i]  = op;
        req_rs1[i] = a;
        req_rs2[i] = b;
        req_id[i]  = id;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ack    = 2'b00;
        unit_stall = 1'b0;
        unit_cap   = 2;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ack   = 2'b11;
        #4;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (unit_new_request !== 1'b0) begin failures++; $display("FAIL reset_new_req: got %b want 0", unit_new_request); end
        checks++; if (unit_ack !== 1'b0) begin failures++; $display("FAIL reset_unit_ack: got %b want 0", unit_ack); end
        next_cycle();
        rst       = 1'b0;
        req_valid = 2'b00;
        #4;
        checks++; if (rsp_done !== 2'b00) begin failures++; $display("FAIL post_reset_rsp_done: got %b want 00", rsp_done); end
        checks++; if (unit_ack !== 1'b0) begin failures++; $display("FAIL post_reset_unit_ack: got %b want 0", unit_ack); end
        next_cycle();
    endtask

    task automatic test_single_eq();
        do_reset();
        set_req(0, FPEQ_OP, 34'h0_3F80_0000, 34'h0_3F80_0000, 3'd5);
        req_valid = 2'b01;
        #4;
        checks++; if (unit_new_request !== 1'b1 || req_ready !== 2'b01) begin failures++; $display("FAIL single_issue: new_req=%b ready=%b want 1/01", unit_new_request, req_ready); end
        checks++; if (unit_id !== 3'd5 || unit_op !== FPEQ_OP) begin failures++; $display("FAIL single_fields: id=%0d op=%0d want 5/%0d", unit_id, unit_op, FPEQ_OP); end
        next_cycle();
        req_valid = 2'b00;
        rsp_ack   = 2'b01;
        #4;
        checks++; if (rsp_done !== 2'b01 || rsp_id !== 3'd5) begin failures++; $display("FAIL single_rsp: done=%b id=%0d want 01/5", rsp_done, rsp_id); end
        checks++; if (rsp_rd !== 32'd1 || unit_ack !== 1'b1) begin failures++; $display("FAIL single_result: rd=%0d ack=%b want 1/1", rsp_rd, unit_ack); end
        next_cycle();
        rsp_ack = 2'b00;
        #4;
        checks++; if (rsp_done !== 2'b00) begin failures++; $display("FAIL single_drained: got %b want 00", rsp_done); end
        next_cycle();
    endtask

    task automatic test_alternation();
        do_reset();
        set_req(0, FPLT_OP, 34'h0_0000_0011, 34'h0_0000_0022, 3'd1);
        set_req(1, FPLE_OP, 34'h0_0000_0033, 34'h0_0000_0044, 3'd2);
        req_valid = 2'b11;
        rsp_ack   = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #4;
            checks++;
            if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL alternate_grant%0d: got %b want %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            next_cycle();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_routing();
        do_reset();
        set_req(0, FPLT_OP, 34'h0_0000_0100, 34'h0_0000_0200, 3'd1);
        req_valid = 2'b01;
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL route_grant0: got %b want 01", req_ready); end
        next_cycle();
        set_req(1, FPCLASS_OP, 34'h0_0000_0300, 34'h0_0000_0400, 3'd2);
        req_valid = 2'b10;
        #4;
        checks++; if (req_ready !== 2'b10 || rsp_done !== 2'b01) begin failures++; $display("FAIL route_grant1: ready=%b done=%b want 10/01", req_ready, rsp_done); end
        next_cycle();
        req_valid = 2'b00;
        rsp_ack   = 2'b10;
        #4;
        checks++; if (rsp_done !== 2'b01 || rsp_id !== 3'd1 || unit_ack !== 1'b0) begin failures++; $display("FAIL route_wrong_ack: done=%b id=%0d ack=%b want 01/1/0", rsp_done, rsp_id, unit_ack); end
        next_cycle();
        rsp_ack = 2'b01;
        #4;
        checks++; if (unit_ack !== 1'b1) begin failures++; $display("FAIL route_ack0: got %b want 1", unit_ack); end
        next_cycle();
        rsp_ack = 2'b00;
        #4;
        checks++; if (rsp_done !== 2'b10 || rsp_id !== 3'd2) begin failures++; $display("FAIL route_rsp1: done=%b id=%0d want 10/2", rsp_done, rsp_id); end
        next_cycle();
    endtask

    task automatic test_stall_full();
        do_reset();
        unit_cap = 1;
        set_req(0, FPCVT_W_OP, 34'h0_0000_0005, 34'h0_0000_0006, 3'd1);
        req_valid = 2'b01;
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL stall_first: got %b want 01", req_ready); end
        next_cycle();
        set_req(0, FPCVT_WU_OP, 34'h0_0000_0007, 34'h0_0000_0008, 3'd2);
        for (int c = 0; c < 5; c++) begin
            #4;
            checks++;
            if (unit_ready !== 1'b0 || req_ready !== 2'b00 || rsp_done !== 2'b01) begin
                failures++;
                $display("FAIL stall_cycle%0d: unit_ready=%b ready=%b done=%b want 0/00/01", c, unit_ready, req_ready, rsp_done);
            end
            next_cycle();
        end
        rsp_ack = 2'b01;
        #4;
        checks++; if (unit_ack !== 1'b1 || req_ready !== 2'b00) begin failures++; $display("FAIL stall_release: ack=%b ready=%b want 1/00", unit_ack, req_ready); end
        next_cycle();
        rsp_ack = 2'b00;
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL stall_resume: got %b want 01", req_ready); end
        next_cycle();
        unit_cap = 4;
        set_req(0, FPMV_X_W_OP, 34'h0_0000_0009, 34'h0_0000_000A, 3'd3);
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL full_fill: got %b want 01", req_ready); end
        next_cycle();
        set_req(0, FPLE_OP, 34'h0_0000_000B, 34'h0_0000_000C, 3'd4);
        #4;
        checks++; if (unit_ready !== 1'b1 || req_ready !== 2'b00) begin failures++; $display("FAIL full_block: unit_ready=%b ready=%b want 1/00", unit_ready, req_ready); end
        next_cycle();
        rsp_ack = 2'b01;
        #4;
        checks++; if (unit_ack !== 1'b1 || req_ready !== 2'b00) begin failures++; $display("FAIL full_pop_same_cycle: ack=%b ready=%b want 1/00", unit_ack, req_ready); end
        next_cycle();
        rsp_ack = 2'b00;
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL full_after_pop: got %b want 01", req_ready); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, FPEQ_OP, 34'h0_0000_0001, 34'h0_0000_0002, 3'd3);
        set_req(1, FPLT_OP, 34'h0_0000_0003, 34'h0_0000_0004, 3'd6);
        req_valid = 2'b01;
        #4;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_issue: got %b want 01", req_ready); end
        next_cycle();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ack   = 2'b01;
        #4;
        checks++; if (req_ready !== 2'b00 || unit_new_request !== 1'b0 || rsp_done !== 2'b00 || unit_ack !== 1'b0) begin failures++; $display("FAIL mid_in_reset: ready=%b new=%b done=%b ack=%b want all 0", req_ready, unit_new_request, rsp_done, unit_ack); end
        next_cycle();
        rst = 1'b0;
        #4;
        checks++; if (rsp_done !== 2'b00 || req_ready !== 2'b01) begin failures++; $display("FAIL mid_after_reset: done=%b ready=%b want 00/01", rsp_done, req_ready); end
        next_cycle();
        #4;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL mid_second_grant: got %b want 10", req_ready); end
        next_cycle();
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        int         w;
        logic [1:0] exp_rdy;
        logic [1:0] exp_d;
        do_reset();
        unit_cap = 3;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || last_grant[i]) begin
                    logic [33:0] a;
                    a = 34'({$urandom(), $urandom()});
                    set_req(i, fp_to_gp_op_t'(3'($urandom_range(0, 6))), a,
                            ($urandom_range(0, 1) == 0) ? a : 34'({$urandom(), $urandom()}),
                            id_t'($urandom_range(0, 7)));
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                end
            end
            rsp_ack    = 2'($urandom_range(0, 3));
            unit_stall = ($urandom_range(0, 4) == 0);
            #4;
            w       = exp_winner();
            exp_rdy = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
            exp_d   = exp_done();
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
            checks++; if (unit_new_request !== (w >= 0)) begin failures++; $display("FAIL rand_new_req c%0d: got %b want %b", c, unit_new_request, (w >= 0)); end
            if (w >= 0) begin
                checks++;
                if (unit_id !== req_id[w] || unit_op !== req_op[w] || unit_rs1 !== req_rs1[w] || unit_rs2 !== req_rs2[w]) begin
                    failures++;
                    $display("FAIL rand_mux c%0d: id=%0d op=%0d want id=%0d op=%0d from req%0d", c, unit_id, unit_op, req_id[w], req_op[w], w);
                end
            end
            checks++; if (rsp_done !== exp_d) begin failures++; $display("FAIL rand_rsp_done c%0d: got %b want %b", c, rsp_done, exp_d); end
            checks++; if (unit_ack !== exp_ack()) begin failures++; $display("FAIL rand_unit_ack c%0d: got %b want %b", c, unit_ack, exp_ack()); end
            if (unit_done && exp_q.size() > 0) begin
                checks++;
                if (rsp_id !== exp_q[0].id || rsp_rd !== exp_q[0].rd) begin
                    failures++;
                    $display("FAIL rand_rsp_data c%0d: id=%0d rd=%h want id=%0d rd=%h", c, rsp_id, rsp_rd, exp_q[0].id, exp_q[0].rd);
                end
            end
            next_cycle();
        end
        req_valid = 2'b00;
    endtask

`ifdef FP_TO_GP_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        set_req(0, FPLT_OP, 34'h0_0000_0011, 34'h0_0000_0022, 3'd1);
        set_req(1, FPLE_OP, 34'h0_0000_0033, 34'h0_0000_0044, 3'd2);
        req_valid = 2'b11;
        rsp_ack   = 2'b11;
        for (int c = 0; c < 10; c++) begin
            #4;
            next_cycle();
        end
        req_valid = 2'b00;
        #4;
        checks++; if (stat_grants0 !== 32'd5 || stat_grants1 !== 32'd5) begin failures++; $display("FAIL stats_grants: g0=%0d g1=%0d want 5/5", stat_grants0, stat_grants1); end
        checks++; if (stat_conflicts !== 32'd10) begin failures++; $display("FAIL stats_conflicts: got %0d want 10", stat_conflicts); end
        next_cycle();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 2'b00;
        rsp_ack     = 2'b00;
        unit_cap    = 2;
        unit_stall  = 1'b0;
        last_winner = -1;
        last_grant  = 2'b00;
        for (int i = 0; i < 2; i++) set_req(i, FPEQ_OP, '0, '0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_single_eq();
        test_alternation();
        test_routing();
        test_stall_full();
        test_reset_mid();
        test_random();
`ifdef FP_TO_GP_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
